// File: rtl/converter_pkg.sv
// Shared sizes and dispatch-state encoding for the converter input packer.
package converter_pkg;

   localparam int BLOCK_W         = 128;
   localparam int BYTE_W          = 8;
   localparam int BYTES_PER_BLOCK = 16;
   localparam int CONV_LATENCY    = 15;
   localparam int TIMEOUT_CYCLES  = 32;

   localparam int FILL_W = $clog2(BYTES_PER_BLOCK);
   localparam int WDOG_W = 6;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      BUSY = 2'd2
   } disp_state_e;

endpackage

// File: rtl/packer_byte_buffer.sv
// One 128-bit block buffer: MSB-first byte-lane write, full flag with set/clear.
module packer_byte_buffer
   import converter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en_i,
   input  logic [FILL_W-1:0]  wr_idx_i,
   input  logic [BYTE_W-1:0]  wr_byte_i,
   input  logic               set_full_i,
   input  logic               clr_i,
   output logic [BLOCK_W-1:0] data_o,
   output logic               full_o
);

   logic [BLOCK_W-1:0] data_q;
   logic               full_q;

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
   // the data array is reset too, so conv_data reads 0 after reset instead of X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
            if (wr_en_i && (wr_idx_i == i[FILL_W-1:0]))
               data_q[BLOCK_W-1-BYTE_W*i -: BYTE_W] <= wr_byte_i;
         end
         if (clr_i)
            full_q <= 1'b0;
         else if (set_full_i)
            full_q <= 1'b1;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/converter_input_packer.sv
// Packs a byte stream into ping-pong 128-bit blocks and dispatches them to a serial converter.
// Optional BUSY watchdog enabled with macro PACKER_TIMEOUT_EN.
module converter_input_packer
   import converter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [BYTE_W-1:0]  in_data,
   output logic               in_ready,
   output logic               conv_start,
   output logic [BLOCK_W-1:0] conv_data,
   input  logic               conv_done,
   output logic               timeout_err
);

   disp_state_e        state_q;
   logic               wr_ptr_q;
   logic               rd_ptr_q;
   logic [FILL_W-1:0]  fill_q;
   logic [1:0]         full;
   logic [BLOCK_W-1:0] buf_data [2];

   logic accept;
   logic last_byte;
   logic blk_release;
   logic timeout_hit;

   assign in_ready    = ~full[wr_ptr_q];
   assign accept      = in_valid & in_ready;
   assign last_byte   = accept && (fill_q == FILL_W'(BYTES_PER_BLOCK - 1));
   assign blk_release = (state_q == BUSY) && (conv_done || timeout_hit);

   for (genvar g = 0; g < 2; g++) begin : g_buf
      packer_byte_buffer u_buf (
         .clk        (clk),
         .rst        (rst),
         .wr_en_i    (accept && (wr_ptr_q == 1'(g))),
         .wr_idx_i   (fill_q),
         .wr_byte_i  (in_data),
         .set_full_i (last_byte && (wr_ptr_q == 1'(g))),
         .clr_i      (blk_release && (rd_ptr_q == 1'(g))),
         .data_o     (buf_data[g]),
         .full_o     (full[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q   <= '0;
         wr_ptr_q <= 1'b0;
      end else if (accept) begin
         fill_q <= fill_q + 1'b1;
         if (last_byte)
            wr_ptr_q <= ~wr_ptr_q;
      end
   end

   // Start is decoded from the IDLE state so a block filled at edge N starts in the next cycle.
   assign conv_start = (state_q == IDLE) && full[rd_ptr_q];
   assign conv_data  = buf_data[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= INIT;
         rd_ptr_q <= 1'b0;
      end else begin
         case (state_q)
            INIT: state_q <= IDLE;
            IDLE: if (full[rd_ptr_q]) state_q <= BUSY;
            BUSY: begin
               if (blk_release) begin
                  state_q  <= IDLE;
                  rd_ptr_q <= ~rd_ptr_q;
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end

`ifdef PACKER_TIMEOUT_EN
   localparam logic [WDOG_W-1:0] TIMEOUT_PRE = WDOG_W'(TIMEOUT_CYCLES - 2);

   logic [WDOG_W-1:0] wdog_q;
   logic              timeout_q;

   // timeout_q is raised one cycle early so the pulse lands on the 32nd BUSY cycle,
   // and the release happens at the end of that same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if ((state_q == BUSY) && !blk_release) begin
            wdog_q <= wdog_q + 1'b1;
            if ((wdog_q == TIMEOUT_PRE) && !conv_done)
               timeout_q <= 1'b1;
         end else begin
            wdog_q <= '0;
         end
      end
   end

   assign timeout_hit = timeout_q;
   assign timeout_err = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule
